// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32 core: operand forwarding from EX/MEM and MEM/WB,
// load-use bubble insertion and a valid/ready handshake with decode and execute.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            id_uses_rs2,
    input  logic [1:0]      id_alu_ops,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_30,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,

    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,

    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_read1,
    output logic [XLEN-1:0] ex_read2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [1:0]      ex_ops,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_30,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            load_use_stall
);

    // EX/MEM wins over MEM/WB; x0 is hard-wired zero and never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic [XLEN-1:0] rf_data,
        input logic [RA_W-1:0] f_exm_rd,
        input logic            f_exm_we,
        input logic [XLEN-1:0] f_exm_val,
        input logic [RA_W-1:0] f_wb_rd,
        input logic            f_wb_we,
        input logic [XLEN-1:0] f_wb_val
    );
        logic [XLEN-1:0] sel;
        sel = rf_data;
        if (f_exm_we && (f_exm_rd != '0) && (f_exm_rd == src))
            sel = f_exm_val;
        else if (f_wb_we && (f_wb_rd != '0) && (f_wb_rd == src))
            sel = f_wb_val;
        return sel;
    endfunction

    logic            vld_p1;
    logic [XLEN-1:0] read1_p1;
    logic [XLEN-1:0] read2_p1;
    logic [XLEN-1:0] store_p1;
    logic [1:0]      ops_p1;
    logic [2:0]      funct3_p1;
    logic            funct7_30_p1;
    logic [RA_W-1:0] rd_p1;
    logic            reg_write_p1;
    logic            mem_read_p1;
    logic            mem_write_p1;

    logic [XLEN-1:0] rs1_fwd_p0;
    logic [XLEN-1:0] rs2_fwd_p0;
    logic            advance;
    logic            capture;

    // Stage p0: decode-side forwarding and hazard resolution
    assign rs1_fwd_p0 = fwd_sel(id_rs1, id_rs1_data, exm_rd, exm_reg_write, exm_result,
                                wb_rd, wb_reg_write, wb_result);
    assign rs2_fwd_p0 = fwd_sel(id_rs2, id_rs2_data, exm_rd, exm_reg_write, exm_result,
                                wb_rd, wb_reg_write, wb_result);

    assign load_use_stall = id_valid && vld_p1 && mem_read_p1 && (rd_p1 != '0) &&
                            ((rd_p1 == id_rs1) || (id_uses_rs2 && (rd_p1 == id_rs2)));

    assign advance  = !vld_p1 || ex_ready;
    assign id_ready = advance && !load_use_stall;
    assign capture  = advance && id_valid && !load_use_stall && !flush;

    // Stage p1: control half of the register; flush and bubbles clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
        end else if (flush || (advance && !capture)) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
        end else if (capture) begin
            vld_p1       <= 1'b1;
            reg_write_p1 <= id_reg_write;
            mem_read_p1  <= id_mem_read;
            mem_write_p1 <= id_mem_write;
        end
    end

    // Datapath fields only move on capture, so a held entry keeps its forwarded operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read1_p1     <= '0;
            read2_p1     <= '0;
            store_p1     <= '0;
            ops_p1       <= '0;
            funct3_p1    <= '0;
            funct7_30_p1 <= 1'b0;
            rd_p1        <= '0;
        end else if (capture) begin
            read1_p1     <= rs1_fwd_p0;
            read2_p1     <= id_use_imm ? id_imm : rs2_fwd_p0;
            store_p1     <= rs2_fwd_p0;
            ops_p1       <= id_alu_ops;
            funct3_p1    <= id_funct3;
            funct7_30_p1 <= id_funct7_30;
            rd_p1        <= id_rd;
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_read1      = read1_p1;
    assign ex_read2      = read2_p1;
    assign ex_store_data = store_p1;
    assign ex_ops        = ops_p1;
    assign ex_funct3     = funct3_p1;
    assign ex_funct7_30  = funct7_30_p1;
    assign ex_rd         = rd_p1;
    assign ex_reg_write  = reg_write_p1;
    assign ex_mem_read   = mem_read_p1;
    assign ex_mem_write  = mem_write_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model pushes expected entries on capture
// and the held entry is compared every cycle until execute consumes it or it is flushed.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm, id_uses_rs2;
    logic [1:0]  id_alu_ops;
    logic [2:0]  id_funct3;
    logic        id_funct7_30, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  exm_rd, wb_rd;
    logic        exm_reg_write, wb_reg_write;
    logic [31:0] exm_result, wb_result;
    logic        flush, ex_ready, ex_valid;
    logic [31:0] ex_read1, ex_read2, ex_store_data;
    logic [1:0]  ex_ops;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_30;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_uses_rs2(id_uses_rs2),
        .id_alu_ops(id_alu_ops), .id_funct3(id_funct3), .id_funct7_30(id_funct7_30),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_read1(ex_read1), .ex_read2(ex_read2), .ex_store_data(ex_store_data),
        .ex_ops(ex_ops), .ex_funct3(ex_funct3), .ex_funct7_30(ex_funct7_30),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1, r2, sd;
        logic [4:0]  rd;
        logic [1:0]  ops;
        logic [2:0]  f3;
        logic        f7, rw, mr, mw;
    } exp_t;

    exp_t sb_q[$];
    int   tests  = 0;
    int   errors = 0;
    logic       m_valid = 1'b0;
    logic       m_mr    = 1'b0;
    logic [4:0] m_rd    = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] s, input logic [31:0] rf);
        if (exm_reg_write && exm_rd != 5'd0 && exm_rd == s) return exm_result;
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == s) return wb_result;
        return rf;
    endfunction

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_use_imm = 0; id_uses_rs2 = 0; id_alu_ops = 0; id_funct3 = 0; id_funct7_30 = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exm_rd = 0; exm_reg_write = 0; exm_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic check_outputs();
        exp_t e;
        check_val("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        if (m_valid) begin
            if (sb_q.size() == 0) begin
                check_val("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q[0];
                check_val("ex_read1", ex_read1, e.r1);
                check_val("ex_read2", ex_read2, e.r2);
                check_val("ex_store_data", ex_store_data, e.sd);
                check_val("ex_rd", {27'b0, ex_rd}, {27'b0, e.rd});
                check_val("ex_ops", {30'b0, ex_ops}, {30'b0, e.ops});
                check_val("ex_funct3", {29'b0, ex_funct3}, {29'b0, e.f3});
                check_val("ex_funct7_30", {31'b0, ex_funct7_30}, {31'b0, e.f7});
                check_val("ex_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write},
                          {29'b0, e.rw, e.mr, e.mw});
            end
        end else begin
            check_val("bubble_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        end
    endtask

    // One clock: check the combinational handshake, step the model, check the register.
    task automatic cycle();
        logic stall_e, adv;
        exp_t e, d;
        @(negedge clk);
        stall_e = id_valid && m_valid && m_mr && (m_rd != 0) &&
                  ((m_rd == id_rs1) || (id_uses_rs2 && (m_rd == id_rs2)));
        adv = !m_valid || ex_ready;
        check_val("load_use_stall", {31'b0, load_use_stall}, {31'b0, stall_e});
        check_val("id_ready", {31'b0, id_ready}, {31'b0, adv && !stall_e});
        if (flush) begin
            if (m_valid && sb_q.size() > 0) d = sb_q.pop_front();
            m_valid = 0; m_mr = 0;
        end else if (adv) begin
            if (m_valid && sb_q.size() > 0) d = sb_q.pop_front();
            if (id_valid && !stall_e) begin
                e.r1 = model_fwd(id_rs1, id_rs1_data);
                e.sd = model_fwd(id_rs2, id_rs2_data);
                e.r2 = id_use_imm ? id_imm : e.sd;
                e.rd = id_rd; e.ops = id_alu_ops; e.f3 = id_funct3; e.f7 = id_funct7_30;
                e.rw = id_reg_write; e.mr = id_mem_read; e.mw = id_mem_write;
                sb_q.push_back(e);
                m_valid = 1; m_mr = id_mem_read; m_rd = id_rd;
            end else begin
                m_valid = 0; m_mr = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
        $fatal(1, "bench timeout");
    end

    initial begin
        idle();
        rst_n = 0;
        // Reset with random inputs on the pins
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); ex_ready = 1'($urandom);
            exm_rd = 5'($urandom); exm_reg_write = 1'($urandom); exm_result = $urandom;
            @(posedge clk); #1;
        end
        check_val("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check_val("rst_read1", ex_read1, 32'd0);
        check_val("rst_read2", ex_read2, 32'd0);
        check_val("rst_store", ex_store_data, 32'd0);
        check_val("rst_misc", {19'b0, ex_ops, ex_funct3, ex_funct7_30, ex_rd,
                               ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        check_val("rst_id_ready", {31'b0, id_ready}, 32'd1);
        check_val("rst_stall", {31'b0, load_use_stall}, 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1;
        cycle();

        // Forwarding from EX/MEM, and EX/MEM priority over WB
        id_valid = 1; id_rs1 = 5; id_rs1_data = 32'hDEAD; id_rd = 6; id_reg_write = 1;
        id_alu_ops = 2'b10; id_funct3 = 3'b000;
        exm_rd = 5; exm_reg_write = 1; exm_result = 32'h10;
        cycle();
        check_val("fwd_exm", ex_read1, 32'h10);
        wb_rd = 5; wb_reg_write = 1; wb_result = 32'h20; id_funct7_30 = 1;
        cycle();
        check_val("fwd_exm_prio", ex_read1, 32'h10);
        exm_reg_write = 0;
        cycle();
        check_val("fwd_wb", ex_read1, 32'h20);

        // x0 is never forwarded
        idle(); id_valid = 1; id_rs1 = 0; id_rs1_data = 0;
        exm_rd = 0; exm_reg_write = 1; exm_result = 32'h777;
        wb_rd = 0; wb_reg_write = 1; wb_result = 32'h888;
        cycle();
        check_val("x0_guard", ex_read1, 32'd0);

        // Load-use: one bubble, then the dependent store picks up exm_result
        idle(); id_valid = 1; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
        id_rs1 = 1; id_rs1_data = 32'h100;
        cycle();
        id_rd = 8; id_mem_read = 0; id_reg_write = 0; id_mem_write = 1;
        id_rs1 = 2; id_rs1_data = 32'h200; id_rs2 = 7; id_uses_rs2 = 1; id_rs2_data = 32'hBAD;
        id_funct3 = 3'b010;
        #1;
        check_val("lu_stall", {31'b0, load_use_stall}, 32'd1);
        check_val("lu_id_ready", {31'b0, id_ready}, 32'd0);
        cycle();
        check_val("lu_bubble", {31'b0, ex_valid}, 32'd0);
        exm_rd = 7; exm_reg_write = 1; exm_result = 32'hCAFE;
        cycle();
        check_val("lu_capture", {31'b0, ex_valid}, 32'd1);
        check_val("lu_store_fwd", ex_store_data, 32'hCAFE);

        // Backpressure: entry holds, forwarding not re-evaluated; then flush kills it
        idle(); id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h33; id_rd = 9; id_reg_write = 1;
        cycle();
        ex_ready = 0; id_rs1_data = 32'h44; id_rd = 10;
        exm_rd = 3; exm_reg_write = 1; exm_result = 32'h99;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("hold_read1", ex_read1, 32'h33);
            check_val("hold_id_ready", {31'b0, id_ready}, 32'd0);
        end
        flush = 1;
        cycle();
        check_val("flush_valid", {31'b0, ex_valid}, 32'd0);
        check_val("flush_reg_write", {31'b0, ex_reg_write}, 32'd0);

        // Flush concurrent with a load-use stall yields a bubble
        idle(); id_valid = 1; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
        cycle();
        id_mem_read = 0; id_rs1 = 7; id_rd = 11; flush = 1;
        cycle();
        check_val("flush_stall_bubble", {31'b0, ex_valid}, 32'd0);
        flush = 0;
        cycle();

        // Immediate select vs. store data
        idle(); id_valid = 1; id_use_imm = 1; id_imm = 32'hFFFFFFFC; id_rs2 = 6;
        id_rs2_data = 32'h11; wb_rd = 6; wb_reg_write = 1; wb_result = 32'h55; id_mem_write = 1;
        cycle();
        check_val("imm_read2", ex_read2, 32'hFFFFFFFC);
        check_val("imm_store", ex_store_data, 32'h55);

        // Asynchronous reset mid-operation, then capture resumes
        idle(); id_valid = 1; id_rs1 = 4; id_rs1_data = 32'h1234; id_rd = 4;
        cycle();
        ex_ready = 0;
        #2 rst_n = 0;
        #1;
        check_val("async_rst_valid", {31'b0, ex_valid}, 32'd0);
        check_val("async_rst_read1", ex_read1, 32'd0);
        m_valid = 0; m_mr = 0; m_rd = 0; sb_q.delete();
        @(negedge clk);
        rst_n = 1; ex_ready = 1;
        cycle();
        check_val("resume_read1", ex_read1, 32'h1234);

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_use_imm = 1'($urandom); id_uses_rs2 = 1'($urandom);
            id_alu_ops = 2'($urandom); id_funct3 = 3'($urandom); id_funct7_30 = 1'($urandom);
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
            exm_rd = 5'($urandom_range(0, 3)); exm_reg_write = 1'($urandom); exm_result = $urandom;
            wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom); wb_result = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
